// File: rtl/pe_pkg.sv
// Shared processing-element constants and the push/pop operation encoding
// used by the PE input FIFO.
package pe_pkg;

    localparam int PE_DATA_W     = 32;
    localparam int PE_FIFO_DEPTH = 4;

    typedef enum logic [1:0] {
        FIFO_IDLE = 2'b00,
        FIFO_POP  = 2'b01,
        FIFO_PUSH = 2'b10,
        FIFO_BOTH = 2'b11
    } fifo_op_e;

    function automatic fifo_op_e fifo_op(input logic push, input logic pop);
        return fifo_op_e'({push, pop});
    endfunction

endpackage

// File: rtl/pe_fifo_ptr.sv
// DEPTH-modulo FIFO pointer: increments on incr, wraps DEPTH-1 -> 0,
// synchronous clear, asynchronous active-high reset.
module pe_fifo_ptr #(
    parameter int DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     clear,
    input  logic                     incr,
    output logic [$clog2(DEPTH)-1:0] ptr
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    logic [AW-1:0] ptr_q;
    logic [AW-1:0] ptr_d;

    // NOTE: every combinational output gets a default first so no path can infer a latch.
    always_comb begin
        ptr_d = ptr_q;
        if (clear) begin
            ptr_d = '0;
        end else if (incr) begin
            ptr_d = (ptr_q == LAST) ? '0 : ptr_q + AW'(1);
        end
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr = ptr_q;

endmodule

// File: rtl/pe_input_fifo.sv
// First-word fall-through input FIFO feeding the PE register; in_ready depends
// only on stored state, and flush beats any same-cycle push or pop.
module pe_input_fifo
    import pe_pkg::*;
#(
    parameter int WIDTH = PE_DATA_W,
    parameter int DEPTH = PE_FIFO_DEPTH
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic [WIDTH-1:0]         in_data,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic [WIDTH-1:0]         out_data,
    input  logic                     out_ready,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    wr_ptr;
    logic [CW-1:0]    count_q;
    logic [CW-1:0]    count_d;
    logic             overflow_q;
    logic             overflow_d;
    logic             push;
    logic             pop;

    assign in_ready  = (count_q != FULL_COUNT);
    assign out_valid = (count_q != '0);
    assign out_data  = mem_q[rd_ptr];

    assign push = in_valid  & in_ready  & ~flush;
    assign pop  = out_valid & out_ready & ~flush;

    pe_fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
        .clock (clock),
        .reset (reset),
        .clear (flush),
        .incr  (push),
        .ptr   (wr_ptr)
    );

    pe_fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
        .clock (clock),
        .reset (reset),
        .clear (flush),
        .incr  (pop),
        .ptr   (rd_ptr)
    );

    always_comb begin
        count_d    = count_q;
        overflow_d = overflow_q;
        case (fifo_op(push, pop))
            FIFO_PUSH: count_d = count_q + CW'(1);
            FIFO_POP:  count_d = count_q - CW'(1);
            default:   count_d = count_q;
        endcase
        if (in_valid && !in_ready) begin
            overflow_d = 1'b1;
        end
        if (flush) begin
            count_d    = '0;
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // NOTE: storage is deliberately not reset; pointers and count alone decide which entries are valid.
    always_ff @(posedge clock) begin
        if (push) begin
            mem_q[wr_ptr] <= in_data;
        end
    end

    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: doc/pe_input_fifo.md
PE_INPUT_FIFO -- requirements
Module: pe_input_fifo

Interface
REQ-001 SHALL have parameter WIDTH, default 32, data word width in bits.
REQ-002 SHALL have parameter DEPTH, default 4, number of storage entries (power of two, >= 2).
REQ-003 SHALL have port clock  input  1  single clock; all state changes on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port flush  input  1  synchronous clear of all stored entries.
REQ-006 SHALL have port in_valid  input  1  producer has a word on in_data.
REQ-007 SHALL have port in_data  input  WIDTH  word from producer.
REQ-008 SHALL have port in_ready  output  1  FIFO can accept a word this cycle.
REQ-009 SHALL have port out_valid  output  1  head word present on out_data.
REQ-010 SHALL have port out_data  output  WIDTH  head word; drives the downstream PE Register data_in.
REQ-011 SHALL have port out_ready  input  1  downstream consumes head; out_valid & out_ready drives the Register r_enable.
REQ-012 SHALL have port count  output  $clog2(DEPTH)+1  number of stored words.
REQ-013 SHALL have port overflow  output  1  sticky flag: push attempted while full.

Function
REQ-014 SHALL push in_data when in_valid & in_ready at a rising edge.
REQ-015 SHALL pop the head when out_valid & out_ready at a rising edge.
REQ-016 SHALL drive in_ready = (count != DEPTH), combinational from state only, never from out_ready.
REQ-017 SHALL drive out_valid = (count != 0) and out_data = entry at read pointer (first-word fall-through, no output register).
REQ-018 SHALL present a word pushed into an empty FIFO on out_data with out_valid high one cycle after the push edge (latency 1).
REQ-019 SHALL, on simultaneous push and pop with 0 < count < DEPTH, perform both and leave count unchanged.
REQ-020 SHALL, when full, ignore in_valid (no push even if out_ready pops the same cycle); count decrements by 1.
REQ-021 SHALL, when empty, ignore out_ready; count and pointers unchanged.
REQ-022 SHALL wrap read and write pointers from DEPTH-1 to 0.
REQ-023 SHALL hold out_data stable while out_valid & !out_ready.
REQ-024 SHALL set overflow when in_valid & !in_ready at a rising edge; cleared only by reset or flush.
REQ-025 SHALL, on flush, set count, pointers and overflow to 0 at that edge; flush wins over a same-cycle push or pop (both dropped).
REQ-026 SHALL not clear storage contents on flush or reset; only pointers and count define validity.

Reset
REQ-027 SHALL, while reset is high, asynchronously force count=0, read/write pointers=0, overflow=0, hence in_valid ignored, in_ready=1, out_valid=0.
REQ-028 SHALL, on reset asserted mid-operation, discard all stored words immediately without waiting for a clock edge.
REQ-029 SHALL resume normal pushes on the first rising edge after reset deasserts.

Structure
REQ-030 SHALL take WIDTH default and the DEPTH default from constants PE_DATA_W=32 and PE_FIFO_DEPTH=4 in shared package pe_pkg.
REQ-031 SHALL implement each pointer as one instance of sub-module pe_fifo_ptr (DEPTH-modulo incrementing counter with increment, synchronous clear, asynchronous reset).
REQ-032 SHALL keep storage as a DEPTH x WIDTH register array written only on push.

Verification
REQ-033 SHALL test reset: reset=1 mid-stream with count=3 -> count=0, out_valid=0, in_ready=1 before the next edge.
REQ-034 SHALL test fill/drain: push 32'hA5A5A5A5, 32'h5A5A5A5A, 32'h12345678, 32'h00000030 with out_ready=0 -> count=4, in_ready=0; then out_ready=1 -> same four words out in order, out_valid=0 after the 4th.
REQ-035 SHALL test overflow: full FIFO, in_valid=1 with 32'hDEADBEEF, out_ready=0 -> word dropped, overflow=1, count stays 4.
REQ-036 SHALL test simultaneous push/pop: count=2, push 32'h11111111 and pop each cycle for 6 cycles -> count stays 2, output order matches input order across pointer wrap.
REQ-037 SHALL test flush: count=3 with flush=1 and in_valid=1 in the same cycle -> count=0, overflow=0, pushed word not stored.
REQ-038 SHALL test latency: push 32'hCAFEF00D into empty FIFO -> out_valid=1 with out_data=32'hCAFEF00D exactly one cycle later.
